// File: rtl/spi_master.sv
// SPI master for a simple 7-bit-address register memory.
// Each transaction is one 16-bit frame {addr, rnw, wdata}, shifted out MSB first.
// SCLK idles low. MOSI changes at the start of each low phase.
// MISO is sampled in the last clk cycle of each high phase.
// The frame is followed by a HOLD period (CS still low) and then a GAP period
// (CS high, busy still asserted).
module spi_master #(
  parameter int CLKDIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rnw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Terminal value of the divider; one SCLK phase spans CLKDIV clk cycles.
  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_t      state_r;
  logic [7:0]  div_cnt_r;
  logic [3:0]  bit_cnt_r;
  logic [15:0] frame_r;
  logic [7:0]  rx_shift_r;

  // Frame sequencer: drives every output straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 4'd0;
      frame_r    <= 16'h0000;
      rx_shift_r <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 8'h00;
      sclk_pin   <= 1'b0;
      cs_pin     <= 1'b1;
      mosi_pin   <= 1'b0;
    end else begin
      // done is a single-cycle pulse; it is raised only on entry to GAP.
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // busy is the registered flag, so a start in the cycle busy falls
          // has already been rejected while the FSM was still in GAP.
          if (start && !busy) begin
            frame_r   <= {addr, rnw, wdata};
            mosi_pin  <= addr[6];
            cs_pin    <= 1'b0;
            busy      <= 1'b1;
            sclk_pin  <= 1'b0;
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 4'd15;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 8'd0;
            if (!sclk_pin) begin
              sclk_pin <= 1'b1;
            end else begin
              // End of the high phase: sample MISO before SCLK falls.
              // Only the last eight samples (the data byte) survive.
              sclk_pin   <= 1'b0;
              rx_shift_r <= {rx_shift_r[6:0], miso_pin};
              if (bit_cnt_r == 4'd0) begin
                state_r <= HOLD;
              end else begin
                bit_cnt_r <= bit_cnt_r - 4'd1;
                mosi_pin  <= frame_r[bit_cnt_r - 4'd1];
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        HOLD: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 8'd0;
            cs_pin    <= 1'b1;
            mosi_pin  <= 1'b0;
            done      <= 1'b1;
            state_r   <= GAP;
            // frame_r[8] is the latched RnW bit.
            if (frame_r[8]) begin
              rdata <= rx_shift_r;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        GAP: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 8'd0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= 8'd0;
          bit_cnt_r <= 4'd0;
          busy      <= 1'b0;
          sclk_pin  <= 1'b0;
          cs_pin    <= 1'b1;
          mosi_pin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master.
// A CLKDIV=8 instance talks to a behavioural SPI memory slave.
// A CLKDIV=2 instance is used for the phase-width check.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;

  logic       start, rnw, busy, done, sclk, cs, mosi, miso;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  logic       start2, rnw2, busy2, done2, sclk2, cs2, mosi2, miso2;
  logic [6:0] addr2;
  logic [7:0] wdata2, rdata2;

  int errors = 0;
  int checks = 0;

  // 100 MHz system clock.
  always #5 clk = ~clk;

  spi_master #(.CLKDIV(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rnw(rnw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .sclk_pin(sclk), .cs_pin(cs), .mosi_pin(mosi), .miso_pin(miso)
  );

  spi_master #(.CLKDIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rnw(rnw2), .addr(addr2),
    .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2),
    .sclk_pin(sclk2), .cs_pin(cs2), .mosi_pin(mosi2), .miso_pin(miso2)
  );

  // Behavioural SPI memory slave (mode 0, frame = {addr, rnw, data}).
  logic [7:0]  mem [128];
  logic [15:0] sl_sh;
  logic [15:0] sl_frame;
  logic [7:0]  sl_abyte;
  logic [7:0]  sl_tmp;
  int          sl_cnt;

  // A new frame starts when CS falls.
  always @(negedge cs) sl_cnt = 0;

  // Release MISO when CS rises.
  always @(posedge cs) miso = 1'b0;

  // Capture MOSI on each rising SCLK edge; commit writes at the end of the frame.
  always @(posedge sclk) begin
    if (!cs) begin
      sl_sh  = {sl_sh[14:0], mosi};
      sl_cnt = sl_cnt + 1;
      if (sl_cnt == 8) sl_abyte = sl_sh[7:0];
      if (sl_cnt == 16) begin
        sl_frame = sl_sh;
        if (!sl_abyte[0]) mem[sl_abyte[7:1]] = sl_sh[7:0];
      end
    end
  end

  // On reads, present the next data bit after each falling SCLK edge.
  always @(negedge sclk) begin
    if (!cs && sl_abyte[0] && sl_cnt >= 8 && sl_cnt < 16) begin
      sl_tmp = mem[sl_abyte[7:1]];
      miso   = sl_tmp[3'(15 - sl_cnt)];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One transaction on the CLKDIV=8 instance.
  // Returns the cycle offsets of done and of the busy fall, both relative to the accept edge E0.
  // Optional stray start pulses can be injected at given edge offsets.
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                         input int stray_a, input int stray_b,
                         output int t_done, output int t_busy,
                         output int cs_low, output int done_cnt);
    @(negedge clk);
    rnw = r; addr = a; wdata = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rnw = ~r; addr = ~a; wdata = ~w;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_cs", {31'd0, cs}, 32'd0);
    chk("accept_mosi", {31'd0, mosi}, {31'd0, a[6]});
    t_done = -1; t_busy = -1; done_cnt = 0;
    cs_low = cs ? 0 : 1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == stray_a || n == stray_b) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!cs) cs_low++;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = n;
      end
      if (!busy) begin
        t_busy = n;
        break;
      end
    end
    if (t_busy < 0) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        r;
    logic [6:0]  a;
    logic [7:0]  w;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [6];

  int td, tb, csl, dc, run, bad, rises;
  logic prev;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 7'h15, 8'h00, 16'h2B00, 8'h3C};
    vecs[1] = '{1'b0, 7'h15, 8'hA5, 16'h2AA5, 8'h3C};
    vecs[2] = '{1'b0, 7'h03, 8'h5A, 16'h065A, 8'h3C};
    vecs[3] = '{1'b1, 7'h03, 8'h00, 16'h0700, 8'h5A};
    vecs[4] = '{1'b0, 7'h7F, 8'h81, 16'hFE81, 8'h5A};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 16'hFF00, 8'h81};

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h15] = 8'h3C;
    sl_cnt = 0; sl_sh = 16'h0; sl_frame = 16'h0; sl_abyte = 8'h0; sl_tmp = 8'h0;
    miso = 1'b0; miso2 = 1'b0;
    reset = 1'b1;
    start = 1'b0; rnw = 1'b0; addr = 7'h0; wdata = 8'h0;
    start2 = 1'b0; rnw2 = 1'b0; addr2 = 7'h0; wdata2 = 8'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven transactions against the memory slave.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].r, vecs[i].a, vecs[i].w, -1, -1, td, tb, csl, dc);
      chk($sformatf("v%0d_frame", i), {16'd0, sl_frame}, {16'd0, vecs[i].exp_frame});
      chk($sformatf("v%0d_rises", i), sl_cnt, 32'd16);
      chk($sformatf("v%0d_t_done", i), td, 32'd264);
      chk($sformatf("v%0d_t_busy", i), tb, 32'd272);
      chk($sformatf("v%0d_cs_low", i), csl, 32'd264);
      chk($sformatf("v%0d_done_cnt", i), dc, 32'd1);
      chk($sformatf("v%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
    end

    // Stray starts at E0+50 and at the busy-fall edge are both ignored.
    run_txn(1'b1, 7'h03, 8'h00, 50, 272, td, tb, csl, dc);
    chk("stray_frame", {16'd0, sl_frame}, 32'h0700);
    chk("stray_t_done", td, 32'd264);
    chk("stray_t_busy", tb, 32'd272);
    chk("stray_done_cnt", dc, 32'd1);
    chk("stray_rdata", {24'd0, rdata}, 32'h5A);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (!cs || busy) bad++;
    end
    chk("stray_idle", bad, 32'd0);

    // Reset at E0+100 of a read abandons the frame.
    @(negedge clk);
    rnw = 1'b1; addr = 7'h15; wdata = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs", {31'd0, cs}, 32'd1);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);
    @(posedge clk); #1;
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);
    // First cycle after reset: start is accepted.
    @(negedge clk);
    reset = 1'b0; rnw = 1'b0; addr = 7'h44; wdata = 8'h12;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_accept", {31'd0, busy}, 32'd1);
    td = -1; dc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dc++;
        if (td < 0) td = n;
      end
    end
    chk("post_rst_t_done", td, 32'd264);
    chk("post_rst_done_cnt", dc, 32'd1);
    chk("post_rst_mem", {24'd0, mem[7'h44]}, 32'h12);

    // CLKDIV=2 write: every SCLK phase is 2 cycles and done arrives at E0+66.
    @(negedge clk);
    start2 = 1'b1; addr2 = 7'h55; rnw2 = 1'b0; wdata2 = 8'hFF;
    @(posedge clk); #1;
    start2 = 1'b0;
    prev = sclk2; run = 1; bad = 0; rises = 0; td = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done2 && td < 0) td = n;
      if (cs2) begin
        if (run != 2) bad++;
        break;
      end
      if (sclk2 == prev) begin
        run++;
      end else begin
        if (run != 2) bad++;
        if (sclk2) rises++;
        run = 1;
        prev = sclk2;
      end
    end
    chk("div2_phase_width", bad, 32'd0);
    chk("div2_rises", rises, 32'd16);
    chk("div2_t_done", td, 32'd66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
